// File: rtl/anubis_comm_pkg.sv
// Shared definitions for the Anubis serial link: frame geometry, default
// start delay and receiver state encodings.
package anubis_comm_pkg;

  localparam int unsigned DATA_W_DEF      = 128;
  localparam int unsigned FRAME_BITS      = DATA_W_DEF + 1;
  localparam int unsigned START_DELAY_DEF = 1;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } rx_state_e;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Board-side handshake and result bus of the serial frame receiver.
interface serial_frame_receiver_if #(
  parameter int unsigned DATA_W = 128
);

  logic              enable;
  logic              RxD;
  logic              r_sync;
  logic              basys3_acknowledge;
  logic [DATA_W-1:0] data_in;
  logic              encrypt;
  logic              ready;
  logic              busy;

  modport master (
    output enable, RxD, r_sync,
    input  basys3_acknowledge, data_in, encrypt, ready, busy
  );

  modport slave (
    input  enable, RxD, r_sync,
    output basys3_acknowledge, data_in, encrypt, ready, busy
  );

endinterface

// File: rtl/rx_shift_reg.sv
// Serial-in parallel-out staging register; new bits enter at the LSB.
module rx_shift_reg #(
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         shift_en_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (clear_i) begin
      data_q <= '0;
    end else if (shift_en_i) begin
      data_q <= {data_q[W-2:0], bit_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Receives a mode bit plus DATA_W payload bits MSB first under the
// r_sync / acknowledge handshake and presents the completed block.
module serial_frame_receiver
  import anubis_comm_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned START_DELAY = START_DELAY_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic                    clk,
  input logic                    reset_b,
  serial_frame_receiver_if.slave bus
);

  localparam int unsigned DLY_W = 2;

  rx_state_e         state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              mode_q, mode_d;
  logic              ack_q, ack_d;
  logic              enc_q, enc_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] shift_q;
  logic              shift_en_c;
  logic              clear_c;
  logic              abort_c;

  assign abort_c = !bus.enable || !bus.r_sync;

  rx_shift_reg #(.W(DATA_W)) u_shift (
    .clk        (clk),
    .rst_n      (reset_b),
    .clear_i    (clear_c),
    .shift_en_i (shift_en_c),
    .bit_i      (bus.RxD),
    .data_o     (shift_q)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    bit_cnt_d  = bit_cnt_q;
    mode_d     = mode_q;
    ack_d      = ack_q;
    enc_d      = enc_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    data_d     = data_q;
    shift_en_c = 1'b0;
    clear_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!abort_c) begin
          ack_d     = 1'b1;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          clear_c   = 1'b1;
          bit_cnt_d = '0;
          if (START_DELAY == 0) begin
            state_d = RECV;
          end else begin
            dly_d   = DLY_W'(START_DELAY);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        dly_d = dly_q - DLY_W'(1);
        if (dly_q <= DLY_W'(1)) state_d = RECV;
      end
      RECV: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == '0) mode_d = bus.RxD;
        else                 shift_en_c = 1'b1;
        if (bit_cnt_q == CNT_W'(DATA_W)) begin
          // Slice keeps the previous DATA_W-1 bits plus the bit on the wire now.
          data_d    = DATA_W'({shift_q, bus.RxD});
          enc_d     = mode_q;
          ready_d   = 1'b1;
          ack_d     = 1'b0;
          busy_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (abort_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An in-flight frame is dropped whole; previous results stay visible.
    if ((state_q == WAIT || state_q == RECV) && abort_c) begin
      state_d    = IDLE;
      ack_d      = 1'b0;
      busy_d     = 1'b0;
      ready_d    = ready_q;
      data_d     = data_q;
      enc_d      = enc_q;
      mode_d     = mode_q;
      bit_cnt_d  = '0;
      dly_d      = '0;
      shift_en_c = 1'b0;
      clear_c    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      bit_cnt_q <= '0;
      mode_q    <= 1'b0;
      ack_q     <= 1'b0;
      enc_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      bit_cnt_q <= bit_cnt_d;
      mode_q    <= mode_d;
      ack_q     <= ack_d;
      enc_q     <= enc_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
    end
  end

  assign bus.basys3_acknowledge = ack_q;
  assign bus.data_in            = data_q;
  assign bus.encrypt            = enc_q;
  assign bus.ready              = ready_q;
  assign bus.busy               = busy_q;

endmodule
